// File: rtl/errbit_cnt_mc_if.sv
// ---------------------------------------------------------------------------
// errbit_cnt_mc_if
//
// Purpose: groups the chunk-stream handshake and the frame-result bus of the
// bit-error counter into one bundle.
//
// Signals:
//   in_valid   chunk present (source -> counter)
//   in_ready   chunk accepted when in_valid && in_ready (counter -> source)
//   in_last    final chunk of the frame
//   cmp_mode   0 = count ones of hard_chunk, 1 = count hard_chunk ^ ref_chunk
//   hard_chunk CHUNK_W hard decisions
//   ref_chunk  CHUNK_W reference codeword bits (ignored in mode 0)
//   out_valid  frame result valid (held for the hold window)
//   err_count  CNT_W frame error count
//   zero_err   error count is zero
//   len_err    frame closed by the chunk limit without in_last
//   busy       frame in progress
//
// Modports:
//   master  chunk source / result sink
//   slave   the counter itself
// ---------------------------------------------------------------------------
interface errbit_cnt_mc_if #(
  parameter int CHUNK_W   = 850,
  parameter int CHUNK_NUM = 9,
  parameter int CNT_W     = $clog2(CHUNK_W * CHUNK_NUM + 1)
);

  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic               cmp_mode;
  logic [CHUNK_W-1:0] hard_chunk;
  logic [CHUNK_W-1:0] ref_chunk;
  logic               out_valid;
  logic [CNT_W-1:0]   err_count;
  logic               zero_err;
  logic               len_err;
  logic               busy;

  modport master (
    output in_valid,
    output in_last,
    output cmp_mode,
    output hard_chunk,
    output ref_chunk,
    input  in_ready,
    input  out_valid,
    input  err_count,
    input  zero_err,
    input  len_err,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_last,
    input  cmp_mode,
    input  hard_chunk,
    input  ref_chunk,
    output in_ready,
    output out_valid,
    output err_count,
    output zero_err,
    output len_err,
    output busy
  );

endinterface

// File: rtl/errbit_cnt_mc.sv
// ---------------------------------------------------------------------------
// errbit_cnt_mc
//
// Purpose: pipelined bit-error counter for the decoder evaluation path. A
// codeword arrives as CHUNK_W-bit chunks; each chunk contributes either its
// ones (all-zero-codeword mode) or its mismatches against a reference chunk.
// The frame total, a zero-error flag and a framing-error flag are presented
// for DONE_HOLD cycles so a slower clock domain can sample them.
//
// Ports:
//   clk   clock
//   rstn  synchronous, active-low reset
//   bus   errbit_cnt_mc_if.slave (chunk handshake in, frame result out)
//
// Pipeline:
//   S1  per-lane popcounts (CHUNK_W/LANE_W lanes)
//   S2  chunk sum
//   S3  frame accumulator
//   Each stage carries a valid and a last tag; the FSM waits for the last
//   tag to leave S3 before publishing the result.
// ---------------------------------------------------------------------------
module errbit_cnt_mc #(
  parameter int CHUNK_W   = 850,
  parameter int CHUNK_NUM = 9,
  parameter int LANE_W    = 85,
  parameter int DONE_HOLD = 2,
  parameter int CNT_W     = $clog2(CHUNK_W * CHUNK_NUM + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  errbit_cnt_mc_if.slave   bus
);

  localparam int NUM_LANES = CHUNK_W / LANE_W;
  localparam int LANE_CW   = $clog2(LANE_W + 1);
  localparam int SUM_W     = $clog2(CHUNK_W + 1);
  localparam int IDX_W     = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1;
  localparam int HOLD_W    = $clog2(DONE_HOLD + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CHUNK_NUM - 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(DONE_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DRAIN,
    HOLD
  } state_t;

  // FSM and registered outputs
  state_t              r_state;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [CNT_W-1:0]    r_err_count;
  logic                r_zero_err;
  logic                r_len_err;
  logic                r_busy;
  logic [IDX_W-1:0]    r_chunk_idx;
  logic                r_len_pend;
  logic [HOLD_W-1:0]   r_hold_cnt;

  // Pipeline stages
  logic [LANE_CW-1:0]  r_lane_cnt [NUM_LANES];
  logic                r_s1_valid;
  logic                r_s1_last;
  logic [SUM_W-1:0]    r_s2_sum;
  logic                r_s2_valid;
  logic                r_s2_last;
  logic [CNT_W-1:0]    r_acc;
  logic                r_s3_valid;
  logic                r_s3_last;

  // Combinational helpers
  logic [CHUNK_W-1:0]  w_bits;
  logic [LANE_CW-1:0]  w_lane_cnt [NUM_LANES];
  logic [SUM_W-1:0]    w_chunk_sum;
  logic                w_accept;
  logic                w_close;
  logic                w_hold_exit;

  // Mode select is per accepted chunk: mode 1 turns the chunk into a
  // mismatch mask, mode 0 counts the hard decisions directly.
  assign w_bits      = bus.cmp_mode ? (bus.hard_chunk ^ bus.ref_chunk) : bus.hard_chunk;
  assign w_accept    = bus.in_valid && r_in_ready;
  // A frame closes on in_last or on reaching the chunk limit.
  assign w_close     = w_accept && (bus.in_last || (r_chunk_idx == LAST_IDX));
  assign w_hold_exit = (r_state == HOLD) && (r_hold_cnt == '0);

  // First-stage popcount: each lane counts LANE_W bits independently so the
  // adder tree stays shallow before the S1 register.
  always_comb begin : lanePop
    logic [LANE_CW-1:0] v_cnt;
    v_cnt = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      v_cnt = '0;
      for (int b = 0; b < LANE_W; b++) begin
        v_cnt = v_cnt + LANE_CW'(w_bits[l*LANE_W + b]);
      end
      w_lane_cnt[l] = v_cnt;
    end
  end

  // Second-stage reduction of the registered lane counts into a chunk sum.
  always_comb begin : chunkSum
    logic [SUM_W-1:0] v_sum;
    v_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      v_sum = v_sum + SUM_W'(r_lane_cnt[l]);
    end
    w_chunk_sum = v_sum;
  end

  // Pipeline data registers; their contents are only meaningful under the
  // matching valid tag, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        r_lane_cnt[l] <= w_lane_cnt[l];
      end
    end
    if (r_s1_valid) begin
      r_s2_sum <= w_chunk_sum;
    end
  end

  // Pipeline valid/last tags and the frame accumulator. The accumulator is
  // cleared when the hold window ends so the next frame starts from zero;
  // no chunk can be in flight at that point because in_ready is low.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_last  <= w_close;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_valid && r_s1_last;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_valid && r_s2_last;
      if (w_hold_exit) begin
        r_acc <= '0;
      end else if (r_s2_valid) begin
        r_acc <= r_acc + CNT_W'(r_s2_sum);
      end
    end
  end

  // Frame control FSM. in_ready is registered, so it is low for the first
  // cycle after reset release and rises one cycle later. The result fields
  // are latched on HOLD entry and left untouched afterwards.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err_count <= '0;
      r_zero_err  <= 1'b0;
      r_len_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_chunk_idx <= '0;
      r_len_pend  <= 1'b0;
      r_hold_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_close) begin
              r_state    <= DRAIN;
              r_in_ready <= 1'b0;
              // Closing without in_last can only mean the limit was hit.
              r_len_pend <= !bus.in_last;
            end else begin
              r_state     <= ACC;
              r_chunk_idx <= r_chunk_idx + IDX_W'(1);
            end
          end
        end

        DRAIN: begin
          r_in_ready <= 1'b0;
          if (r_s3_valid && r_s3_last) begin
            r_state     <= HOLD;
            r_out_valid <= 1'b1;
            r_err_count <= r_acc;
            r_zero_err  <= (r_acc == '0);
            r_len_err   <= r_len_pend;
            r_hold_cnt  <= HOLD_INIT;
          end
        end

        HOLD: begin
          r_in_ready <= 1'b0;
          if (r_hold_cnt == '0) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_chunk_idx <= '0;
            r_len_pend  <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end

        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.err_count = r_err_count;
  assign bus.zero_err  = r_zero_err;
  assign bus.len_err   = r_len_err;
  assign bus.busy      = r_busy;

endmodule
